ahb_dmem_ctrl: RTL and testbench
================================

AHB_DMEM_CTRL -- requirements
Module: ahb_dmem_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, 1 KB-aligned base of the data memory window.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 HSEL  in  1  slave select; HADDR  in  32  byte address; HTRANS  in  2  transfer type; HWRITE  in  1  1=write.
REQ-006 HSIZE  in  3  transfer size; HWDATA  in  32  write data (data phase); HREADY  in  1  bus ready.
REQ-007 HREADYOUT  out  1  slave ready; HRESP  out  1  0=OKAY, 1=ERROR; HRDATA  out  32  read data.
REQ-008 mem_write  out  1; mem_read  out  1; address_ram  out  32  byte offset from BASE_ADDR; mem_sel  out  1  drives the memory HSEL2.
REQ-009 write_data  out  32  to memory; read_data  in  32  from memory, registered (1-cycle read latency).
REQ-010 rd_count, wr_count, err_count  out  CNT_W each  saturating transfer counters.

Function
REQ-011 Transfer SHALL be accepted when HSEL && HREADY && HTRANS[1]; IDLE/BUSY SHALL get zero-wait OKAY with no memory access.
REQ-012 Accepted transfer SHALL be errored if HSIZE!=3'b010, HADDR[1:0]!=0, or HADDR[31:10]!=BASE_ADDR[31:10].
REQ-013 FSM states: IDLE, WR, RD_WAIT, RD_DATA, ERR1, ERR2; next state is evaluated whenever HREADYOUT=1.
REQ-014 From any HREADYOUT=1 state: accepted good write->WR; good read->RD_WAIT; errored->ERR1; otherwise->IDLE.
REQ-015 WR: mem_write=1, mem_sel=1, address_ram=latched offset, write_data=HWDATA, HREADYOUT=1; memory commits at end of cycle.
REQ-016 RD_WAIT: mem_read=1, mem_sel=1, address_ram=latched offset, HREADYOUT=0; next state always RD_DATA.
REQ-017 RD_DATA: HRDATA=read_data, HREADYOUT=1, mem_read=0; HRDATA SHALL be 0 in all other states.
REQ-018 ERR1: HREADYOUT=0, HRESP=1, next ERR2; ERR2: HREADYOUT=1, HRESP=1; no memory strobe in either.
REQ-019 Write latency SHALL be 0 wait states, read 1 wait state, error exactly 2 cycles.
REQ-020 Read accepted during WR data phase SHALL return the just-written data (write commits before RD_WAIT).
REQ-021 Address latch SHALL update only on accept; mem_* SHALL be 0 outside WR/RD_WAIT.
REQ-022 rd_count/wr_count SHALL increment on entering RD_DATA/WR; err_count on entering ERR1; all saturate at all-ones.

Reset
REQ-023 While reset_n=0: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all mem_* outputs 0, counters 0, latches 0.
REQ-024 Reset asserted mid-transfer SHALL abandon it; no memory write SHALL occur after reset assertion.

Structure
REQ-025 Shared package ahb_pkg SHALL hold HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HRESP codes, HSIZE_WORD and the FSM state enum.
REQ-026 The three counters SHALL be instances of one sub-module sat_counter (parameter width, inc, saturating).

Verification
REQ-027 Write 0x00000010 data 0xCAFEBABE, then read 0x00000010 -> WR zero-wait, read one wait, HRDATA=0xCAFEBABE, HRESP=0.
REQ-028 Back-to-back write 0x20=0x12345678 then pipelined read 0x20 -> HRDATA=0x12345678, wr_count=1, rd_count=1.
REQ-029 Read 0x00000002 and read 0x00000400 -> two-cycle ERROR each, mem_read never 1, err_count=2.
REQ-030 HTRANS=IDLE with HSEL=1 at 0x08 -> HREADYOUT=1, HRESP=0, no mem strobe, counters unchanged.
REQ-031 reset_n low during RD_WAIT -> immediately HREADYOUT=1, mem_read=0, state IDLE, counters 0.
REQ-032 CNT_W=2, five good writes -> wr_count saturates at 3.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the data-memory controller state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD_WAIT, ST_RD_DATA, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/ahb_dmem_ctrl.sv
// ahb_dmem_ctrl: AHB-Lite slave bridging word accesses to a 1 KB synchronous data memory
module ahb_dmem_ctrl
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic             mem_write,
  output logic             mem_read,
  output logic [31:0]      address_ram,
  output logic             mem_sel,
  output logic [31:0]      write_data,
  input  logic [31:0]      read_data,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);
  state_t state, state_nxt;
  logic [31:0] addr_q;
  logic accept, bad;
  assign accept = HSEL && HREADY && HTRANS[1];
  assign bad = HSIZE != HSIZE_WORD || HADDR[1:0] != 2'b00 || HADDR[31:10] != BASE_ADDR[31:10];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_nxt;
  // wait states never re-sample the bus; only ready cycles decode a new address phase
  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_RD_WAIT) state_nxt = ST_RD_DATA;
    else if (state == ST_ERR1) state_nxt = ST_ERR2;
    else if (accept) state_nxt = bad ? ST_ERR1 : HWRITE ? ST_WR : ST_RD_WAIT;
  end
  // the window is 1 KB aligned, so the byte offset is just the low address bits
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) addr_q <= '0;
    else if (accept && HREADYOUT) addr_q <= {22'b0, HADDR[9:0]};
  assign HREADYOUT   = !(state == ST_RD_WAIT || state == ST_ERR1);
  assign HRESP       = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA      = state == ST_RD_DATA ? read_data : '0;
  assign mem_write   = state == ST_WR;
  assign mem_read    = state == ST_RD_WAIT;
  assign mem_sel     = mem_write || mem_read;
  assign address_ram = mem_sel ? addr_q : '0;
  assign write_data  = mem_write ? HWDATA : '0;
  sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
    .clk(clk), .reset_n(reset_n), .inc(state == ST_RD_WAIT), .count(rd_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
    .clk(clk), .reset_n(reset_n), .inc(HREADYOUT && state_nxt == ST_WR), .count(wr_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk(clk), .reset_n(reset_n), .inc(HREADYOUT && state_nxt == ST_ERR1), .count(err_count)
  );
endmodule

// File: tb/tb_ahb_dmem_ctrl.sv
// tb_ahb_dmem_ctrl: vector table, corner sequences and random traffic against a transfer-level model
module tb_ahb_dmem_ctrl;
  import ahb_pkg::*;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int CMAX = 65535;
  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rdata;
    bit        exp_resp;
    int        exp_waits;
    int        exp_wc, exp_rc, exp_ec;
  } vec_t;
  logic clk = 0, reset_n = 0, hready_kill = 0;
  logic HSEL = 0, HWRITE = 0;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 0;
  logic hready, HREADYOUT, HRESP, mem_write, mem_read, mem_sel;
  logic [31:0] HRDATA, address_ram, write_data;
  logic [31:0] read_data = 0;
  logic [15:0] rd_count, wr_count, err_count;
  logic d2_ready, d2_resp, d2_mw, d2_mr, d2_sel;
  logic [31:0] d2_rdata, d2_addr, d2_wdata;
  logic [1:0] d2_rc, d2_wc, d2_ec;
  logic [31:0] mem [256] = '{default: 32'h0};
  int tests = 0, fails = 0;
  int m_wc, m_rc, m_ec;
  bit [31:0] ref_mem [int];
  vec_t tab [14];
  vec_t xq [$];
  always #5 clk = ~clk;
  assign hready = HREADYOUT & ~hready_kill;
  ahb_dmem_ctrl #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(hready), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .mem_write(mem_write), .mem_read(mem_read), .address_ram(address_ram),
    .mem_sel(mem_sel), .write_data(write_data), .read_data(read_data),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );
  ahb_dmem_ctrl #(.BASE_ADDR(BASE), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(hready), .HREADYOUT(d2_ready), .HRESP(d2_resp),
    .HRDATA(d2_rdata), .mem_write(d2_mw), .mem_read(d2_mr), .address_ram(d2_addr),
    .mem_sel(d2_sel), .write_data(d2_wdata), .read_data(read_data),
    .rd_count(d2_rc), .wr_count(d2_wc), .err_count(d2_ec)
  );
  always @(posedge clk) begin
    if (mem_sel && mem_write) mem[address_ram[9:2]] <= write_data;
    if (mem_sel && mem_read) read_data <= mem[address_ram[9:2]];
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd,
                              bit [31:0] rd, bit resp, int w, int wc, int rc, int ec);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
    v.exp_rdata = rd; v.exp_resp = resp; v.exp_waits = w;
    v.exp_wc = wc; v.exp_rc = rc; v.exp_ec = ec;
    return v;
  endfunction
  task automatic model(inout vec_t v);
    bit act, bad;
    int off;
    act = v.sel && v.trans[1];
    bad = act && (v.size != 3'd2 || v.addr % 4 != 0 || v.addr < BASE || v.addr >= BASE + 1024);
    off = int'((v.addr - BASE) % 1024);
    v.exp_resp = bad;
    v.exp_waits = (!act || (!bad && v.wr)) ? 0 : 1;
    v.exp_rdata = (act && !bad && !v.wr && ref_mem.exists(off)) ? ref_mem[off] : 0;
    if (act && !bad && v.wr) begin
      ref_mem[off] = v.wdata;
      if (m_wc < CMAX) m_wc++;
    end
    if (act && !bad && !v.wr && m_rc < CMAX) m_rc++;
    if (bad && m_ec < CMAX) m_ec++;
    v.exp_wc = m_wc; v.exp_rc = m_rc; v.exp_ec = m_ec;
  endtask
  task automatic idle_bus();
    HSEL = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HSIZE = 0; HADDR = 0; HWDATA = 0;
  endtask
  task automatic do_reset();
    idle_bus();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    m_wc = 0; m_rc = 0; m_ec = 0;
  endtask
  task automatic check_done(input vec_t v, input int waits, input int nmw, input int nmr, input int nresp);
    bit good;
    int sat;
    good = v.sel && v.trans[1] && !v.exp_resp;
    sat = v.exp_wc > 3 ? 3 : v.exp_wc;
    chk("hrdata", 64'(HRDATA), 64'(v.exp_rdata));
    chk("resp_cycles", 64'(nresp), 64'(v.exp_resp ? 2 : 0));
    chk("wait_states", 64'(waits), 64'(v.exp_waits));
    chk("strobes", {32'(nmw), 32'(nmr)}, {32'(good && v.wr), 32'(good && !v.wr)});
    chk("counters", 64'({wr_count, rd_count, err_count}),
        64'({16'(v.exp_wc), 16'(v.exp_rc), 16'(v.exp_ec)}));
    chk("wr_count_sat2", 64'(d2_wc), 64'(sat));
  endtask
  // drives xq as a pipelined AHB stream; each entry is checked when its data phase completes
  task automatic run_q();
    int a, d, n, waits, nmw, nmr, nresp, cyc;
    bit adv;
    a = 0; d = -1; n = xq.size(); cyc = 0;
    waits = 0; nmw = 0; nmr = 0; nresp = 0;
    while (a < n || d >= 0) begin
      if (a < n) begin
        HSEL = xq[a].sel; HTRANS = xq[a].trans; HWRITE = xq[a].wr; HSIZE = xq[a].size; HADDR = xq[a].addr;
      end else begin
        HSEL = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HSIZE = 0; HADDR = 0;
      end
      HWDATA = d >= 0 ? xq[d].wdata : 32'h0;
      @(negedge clk);
      if (d >= 0) begin
        nmw += int'(mem_write); nmr += int'(mem_read); nresp += int'(HRESP);
        if (!HREADYOUT) waits++;
        else check_done(xq[d], waits, nmw, nmr, nresp);
      end
      adv = hready;
      @(posedge clk);
      #1;
      if (adv) begin
        waits = 0; nmw = 0; nmr = 0; nresp = 0;
        d = a < n ? a : -1;
        if (a < n) a++;
      end
      cyc++;
      if (cyc > 4 * n + 10) begin
        chk("run_timeout", 64'(cyc), 64'(4 * n + 10));
        break;
      end
    end
    idle_bus();
    xq.delete();
  endtask
  initial begin
    vec_t v;
    tab[0]  = mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h020, 32'h12345678, 32'h0, 0, 0, 1, 0, 0);
    tab[1]  = mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h020, 32'h0, 32'h12345678, 0, 1, 1, 1, 0);
    tab[2]  = mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h010, 32'hCAFEBABE, 32'h0, 0, 0, 2, 1, 0);
    tab[3]  = mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h010, 32'h0, 32'hCAFEBABE, 0, 1, 2, 2, 0);
    tab[4]  = mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h002, 32'h0, 32'h0, 1, 1, 2, 2, 1);
    tab[5]  = mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h400, 32'h0, 32'h0, 1, 1, 2, 2, 2);
    tab[6]  = mk(1, HTRANS_IDLE,   0, 3'd2, 32'h008, 32'h0, 32'h0, 0, 0, 2, 2, 2);
    tab[7]  = mk(1, HTRANS_BUSY,   1, 3'd2, 32'h008, 32'h55, 32'h0, 0, 0, 2, 2, 2);
    tab[8]  = mk(0, HTRANS_NONSEQ, 1, 3'd2, 32'h030, 32'h77, 32'h0, 0, 0, 2, 2, 2);
    tab[9]  = mk(1, HTRANS_NONSEQ, 1, 3'd0, 32'h030, 32'h77, 32'h0, 1, 1, 2, 2, 3);
    tab[10] = mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h3FC, 32'hA5A5A5A5, 32'h0, 0, 0, 3, 2, 3);
    tab[11] = mk(1, HTRANS_SEQ,    0, 3'd2, 32'h3FC, 32'h0, 32'hA5A5A5A5, 0, 1, 3, 3, 3);
    tab[12] = mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0, 0, 0, 4, 3, 3);
    tab[13] = mk(1, HTRANS_SEQ,    0, 3'd2, 32'h010, 32'h0, 32'hDEADBEEF, 0, 1, 4, 4, 3);
    #1;
    chk("reset_outputs", 64'({HREADYOUT, HRESP, HRDATA, mem_write, mem_read, mem_sel, address_ram[15:0]}),
        64'({1'b1, 1'b0, 32'h0, 3'b000, 16'h0}));
    chk("reset_counters", 64'({wr_count, rd_count, err_count}), 64'h0);
    do_reset();
    for (int i = 0; i < 14; i++) xq.push_back(tab[i]);
    run_q();
    for (int i = 0; i < 14; i++) begin
      v = tab[i];
      model(v);
    end
    // reset while a read is in its wait state
    HSEL = 1; HTRANS = HTRANS_NONSEQ; HWRITE = 0; HSIZE = HSIZE_WORD; HADDR = 32'h10;
    @(posedge clk);
    #1 idle_bus();
    chk("rdwait_strobe", 64'({HREADYOUT, mem_read}), 64'({1'b0, 1'b1}));
    reset_n = 0;
    #1;
    chk("rst_in_rdwait", 64'({HREADYOUT, HRESP, mem_read, mem_sel}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    chk("rst_counters", 64'({wr_count, rd_count, err_count}), 64'h0);
    @(posedge clk);
    #1 reset_n = 1;
    m_wc = 0; m_rc = 0; m_ec = 0;
    @(negedge clk);
    chk("after_rst_idle", 64'({HREADYOUT, HRDATA, rd_count}), 64'({1'b1, 32'h0, 16'h0}));
    // reset during a write data phase must suppress the memory commit
    @(posedge clk);
    #1 HSEL = 1; HTRANS = HTRANS_NONSEQ; HWRITE = 1; HSIZE = HSIZE_WORD; HADDR = 32'h44;
    @(posedge clk);
    #1 idle_bus();
    HWDATA = 32'h11111111;
    chk("wr_strobe", 64'({mem_write, mem_sel, address_ram}), 64'({1'b1, 1'b1, 32'h44}));
    reset_n = 0;
    #1 chk("rst_in_wr", 64'({mem_write, mem_sel}), 64'h0);
    @(posedge clk);
    #1 do_reset();
    v = mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    model(v);
    xq.push_back(v);
    run_q();
    // a selected transfer with HREADY low is not accepted
    hready_kill = 1;
    HSEL = 1; HTRANS = HTRANS_NONSEQ; HWRITE = 1; HSIZE = HSIZE_WORD; HADDR = 32'h48;
    @(posedge clk);
    #1 idle_bus();
    hready_kill = 0;
    @(negedge clk);
    chk("hready_low_ignored", 64'({mem_write, HREADYOUT, wr_count}), 64'({1'b0, 1'b1, 16'(m_wc)}));
    // five good writes saturate the 2-bit counter
    @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 5; i++) begin
      v = mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'(i * 4 + 'h100), 32'hA000 + 32'(i), 0, 0, 0, 0, 0, 0);
      model(v);
      xq.push_back(v);
    end
    run_q();
    chk("sat2_final", 64'({d2_wc, wr_count}), 64'({2'd3, 16'd5}));
    // random pipelined traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      v.sel = $urandom_range(0, 9) != 0;
      v.trans = 2'($urandom);
      v.wr = 1'($urandom);
      v.size = $urandom_range(0, 7) == 0 ? 3'($urandom) : 3'd2;
      v.addr = BASE + 32'($urandom_range(0, 15)) * 4;
      if (r == 0) v.addr = $urandom;
      else if (r == 1) v.addr = v.addr | 32'($urandom_range(1, 3));
      else if (r == 2) v.addr = v.addr + 32'h400;
      v.wdata = $urandom;
      model(v);
      xq.push_back(v);
    end
    run_q();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
